// File: rtl/lcd_refresh.sv
// lcd_refresh: reader side of the 128x64 monochrome frame RAM (8 pages x 128 columns,
// address = column + page*128). It continuously scans the RAM and streams it to a
// dual-controller KS0108-style LCD (CS1 = columns 0-63, CS2 = columns 64-127). It also
// handles panel power-up, init commands and E-strobe bus timing.
//
// Optional feature macro: LCD_INVERT_EN (when defined, display-data bytes are inverted).
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous reset, active-high
//   i_refresh_en     1 = keep refreshing frames, 0 = finish current frame then idle
//   o_ram_read_addr  frame-RAM read address (10 bits)
//   i_ram_read_data  frame-RAM read data (8 bits, RD_LAT cycles after address)
//   o_lcd_data       LCD data bus
//   o_lcd_rs         0 = command, 1 = display data
//   o_lcd_rw         tied 0 (write-only)
//   o_lcd_e          enable strobe
//   o_lcd_cs1        left controller select
//   o_lcd_cs2        right controller select
//   o_lcd_rst_n      panel reset, active-low
//   o_busy           high whenever the FSM is not idle
//   o_frame_done     one-cycle pulse after the last data byte of a frame
module lcd_refresh #(
  parameter int unsigned E_HIGH_CYCLES   = 25,
  parameter int unsigned E_LOW_CYCLES    = 25,
  parameter int unsigned POWER_UP_CYCLES = 500000,
  parameter int unsigned RD_LAT          = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_refresh_en,
  output logic [9:0] o_ram_read_addr,
  input  logic [7:0] i_ram_read_data,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic       o_lcd_cs1,
  output logic       o_lcd_cs2,
  output logic       o_lcd_rst_n,
  output logic       o_busy,
  output logic       o_frame_done
);

  // One shared counter covers power-up wait, bus transactions and fetch latency.
  localparam int unsigned CntW =
      $clog2(POWER_UP_CYCLES + E_HIGH_CYCLES + E_LOW_CYCLES + RD_LAT + 2);
  localparam logic [CntW-1:0] PwrLast   = CntW'(POWER_UP_CYCLES - 1);
  localparam logic [CntW-1:0] TxLast    = CntW'(E_HIGH_CYCLES + E_LOW_CYCLES);
  localparam logic [CntW-1:0] EFall     = CntW'(E_HIGH_CYCLES);
  localparam logic [CntW-1:0] FetchLast = CntW'(RD_LAT);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [3:0] {
    StPwrWait,
    StInitOn,
    StInitLine,
    StIdle,
    StPageCmd,
    StColCmd,
    StFetch,
    StDataWr,
    StNext
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_page;
  logic            r_half;
  logic [5:0]      r_col;
  logic [9:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_rs;
  logic            r_e;
  logic            r_cs1;
  logic            r_cs2;
  logic            r_rst_n;
  logic            r_busy;
  logic            r_frame_done;

  logic [7:0]      w_wr_byte;
  logic            w_tx_last;

`ifdef LCD_INVERT_EN
  assign w_wr_byte = ~i_ram_read_data;
`else
  assign w_wr_byte = i_ram_read_data;
`endif

  assign w_tx_last = (r_cnt == TxLast);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StPwrWait;
      r_cnt        <= '0;
      r_page       <= '0;
      r_half       <= 1'b0;
      r_col        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rs         <= 1'b0;
      r_e          <= 1'b0;
      r_cs1        <= 1'b0;
      r_cs2        <= 1'b0;
      r_rst_n      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StPwrWait: begin
          r_busy <= 1'b1;
          if (r_cnt == PwrLast) begin
            r_cnt   <= '0;
            r_rst_n <= 1'b1;
            r_data  <= 8'h3F;
            r_rs    <= 1'b0;
            r_cs1   <= 1'b1;
            r_cs2   <= 1'b1;
            r_state <= StInitOn;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end

        // All bus-transaction states share the setup / E-high / E-low timing. Outputs for
        // the following transaction are loaded on the exit edge so they are valid in its
        // setup cycle.
        StInitOn, StInitLine, StPageCmd, StColCmd, StDataWr: begin
          if (!w_tx_last) begin
            r_cnt <= r_cnt + CntOne;
            r_e   <= (r_cnt < EFall);
          end else begin
            r_cnt <= '0;
            r_e   <= 1'b0;
            unique case (r_state)
              StInitOn: begin
                r_data  <= 8'hC0;
                r_state <= StInitLine;
              end
              StInitLine: begin
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end
              StPageCmd: begin
                r_data  <= 8'h40;
                r_state <= StColCmd;
              end
              StColCmd: begin
                r_col   <= '0;
                r_addr  <= {r_page, r_half, 6'd0};
                r_state <= StFetch;
              end
              default: begin
                r_state <= StNext;
              end
            endcase
          end
        end

        StIdle: begin
          if (i_refresh_en) begin
            r_page  <= '0;
            r_half  <= 1'b0;
            r_data  <= 8'hB8;
            r_rs    <= 1'b0;
            r_cs1   <= 1'b1;
            r_cs2   <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= StPageCmd;
          end
        end

        // Capture the RAM byte once the read pipeline has delivered it.
        StFetch: begin
          if (r_cnt == FetchLast) begin
            r_cnt   <= '0;
            r_data  <= w_wr_byte;
            r_rs    <= 1'b1;
            r_state <= StDataWr;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end

        StNext: begin
          r_cnt <= '0;
          if (r_col != 6'd63) begin
            // Panel auto-increments Y, so just fetch the next column.
            r_col   <= r_col + 6'd1;
            r_addr  <= {r_page, r_half, r_col + 6'd1};
            r_state <= StFetch;
          end else if (!r_half) begin
            r_half  <= 1'b1;
            r_data  <= {5'b10111, r_page};
            r_rs    <= 1'b0;
            r_cs1   <= 1'b0;
            r_cs2   <= 1'b1;
            r_state <= StPageCmd;
          end else if (r_page != 3'd7) begin
            r_page  <= r_page + 3'd1;
            r_half  <= 1'b0;
            r_data  <= {5'b10111, r_page + 3'd1};
            r_rs    <= 1'b0;
            r_cs1   <= 1'b1;
            r_cs2   <= 1'b0;
            r_state <= StPageCmd;
          end else begin
            r_frame_done <= 1'b1;
            r_page       <= '0;
            r_half       <= 1'b0;
            if (i_refresh_en) begin
              r_data  <= 8'hB8;
              r_rs    <= 1'b0;
              r_cs1   <= 1'b1;
              r_cs2   <= 1'b0;
              r_state <= StPageCmd;
            end else begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= StPwrWait;
        end
      endcase
    end
  end

  assign o_ram_read_addr = r_addr;
  assign o_lcd_data      = r_data;
  assign o_lcd_rs        = r_rs;
  assign o_lcd_rw        = 1'b0;
  assign o_lcd_e         = r_e;
  assign o_lcd_cs1       = r_cs1;
  assign o_lcd_cs2       = r_cs2;
  assign o_lcd_rst_n     = r_rst_n;
  assign o_busy          = r_busy;
  assign o_frame_done    = r_frame_done;

endmodule

// File: doc/lcd_refresh.md
Name: lcd_refresh

Overview:
- Reader side of the 128x64 monochrome frame RAM.
- The RAM is written by the pixel/drawing logic. Its layout is 8 pages x 128 columns, one byte per column per page, with address = column + page*128. Bit n of a byte is row page*8+n.
- This block continuously scans that RAM and streams it to a dual-controller KS0108-style parallel LCD: CS1 drives columns 0-63, CS2 drives columns 64-127.
- It owns the RAM read port, power-up/init of the panel, and E-strobe bus timing.

Parameters:
- E_HIGH_CYCLES, 25: clk cycles lcd_e is held high per bus transaction.
- E_LOW_CYCLES, 25: clk cycles lcd_e is held low after the falling edge, before the next transaction.
- POWER_UP_CYCLES, 500000: clk cycles lcd_rst_n is held low after reset, before init starts.
- RD_LAT, 2: frame-RAM read latency in cycles. Data is valid RD_LAT cycles after ram_read_addr changes.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- refresh_en  input  1  1 = keep refreshing frames; 0 = finish the current frame, then idle
- ram_read_addr  output  10  frame-RAM read address
- ram_read_data  input  8  frame-RAM read data
- lcd_data  output  8  LCD data bus
- lcd_rs  output  1  0 = command, 1 = display data
- lcd_rw  output  1  tied 0 (write-only)
- lcd_e  output  1  enable strobe
- lcd_cs1  output  1  select left controller (columns 0-63)
- lcd_cs2  output  1  select right controller (columns 64-127)
- lcd_rst_n  output  1  panel reset, active-low
- busy  output  1  high whenever the FSM is not in IDLE
- frame_done  output  1  one-cycle pulse after the last data byte of page 7 / CS2

Behaviour:

Reset values (asserted asynchronously on rst):
- All outputs 0, including lcd_rst_n = 0.
- FSM enters PWR_WAIT; all counters are cleared.
- Reset mid-transaction aborts immediately. No partial E pulse is completed.

Bus transaction (each command or data byte):
- Cycle 0 (setup): drive lcd_data, lcd_rs, cs1/cs2; lcd_e = 0.
- Next E_HIGH_CYCLES cycles: lcd_e = 1.
- Next E_LOW_CYCLES cycles: lcd_e = 0.
- data, rs and cs stay stable for the whole transaction.
- Total cost: 1 + E_HIGH_CYCLES + E_LOW_CYCLES cycles.

FSM states and transitions:
- PWR_WAIT: lcd_rst_n = 0 for POWER_UP_CYCLES, then lcd_rst_n = 1 for the rest of operation, then go to INIT_ON.
- INIT_ON: command 0x3F (display on), both cs1 and cs2 = 1. Then INIT_LINE.
- INIT_LINE: command 0xC0 (start line 0), both chips. Then IDLE.
- IDLE: busy = 0. When refresh_en = 1, set page = 0, half = 0, go to PAGE_CMD.
- PAGE_CMD: command 0xB8 | page, to the chip selected by half (half 0 -> cs1, half 1 -> cs2). Then COL_CMD.
- COL_CMD: command 0x40 (Y = 0), same chip. Then FETCH with col = 0.
- FETCH: ram_read_addr = page*128 + half*64 + col. Wait RD_LAT cycles, capture ram_read_data, go to DATA_WR.
- DATA_WR: lcd_rs = 1, lcd_data = captured byte. Then NEXT.
- NEXT:
  - If col < 63: col++, go to FETCH. The panel auto-increments Y, so no column command is issued.
  - If col = 63 and half = 0: half = 1, go to PAGE_CMD.
  - If col = 63 and half = 1 and page < 7: page++, half = 0, go to PAGE_CMD.
  - If col = 63 and half = 1 and page = 7: pulse frame_done. Go to PAGE_CMD for page 0 if refresh_en = 1, else IDLE.

Other rules:
- Transactions per frame: 8 pages x 2 halves x (2 + 64) = 1056.
- refresh_en is sampled only at the frame boundary. Deasserting it mid-frame does not shorten the frame.
- Address arithmetic is 10-bit. Page is 3-bit and col is 6-bit; both wrap naturally.
- ram_read_addr holds its last value outside FETCH.
- The RAM is not locked. Bytes written during a scan show up in this frame or the next, depending on scan position.

Optional Feature:
- Macro: LCD_INVERT_EN.
- Defined: display-data bytes are bitwise inverted (~data) before driving lcd_data in DATA_WR, giving white-on-black. Command bytes are unaffected.
- Undefined: data bytes are passed through unchanged.

Test Plan (sim values: E_HIGH_CYCLES = 2, E_LOW_CYCLES = 2, POWER_UP_CYCLES = 10, RD_LAT = 2; RAM model with 2-cycle latency):
- Reset release -> lcd_rst_n low for 10 cycles, then 0x3F and 0xC0 issued, each with cs1 = cs2 = 1 and rs = 0. Each E pulse is high exactly 2 cycles.
- refresh_en = 1, RAM[addr] = addr[7:0] -> first transactions are 0xB8 and 0x40 on cs1, then data 0x00..0x3F on cs1, then 0xB8 and 0x40 on cs2, then data 0x40..0x7F.
- Full frame -> exactly 1056 E pulses after init. frame_done pulses once, one cycle, after the byte from address 1023. The next transaction is 0xB8 on cs1.
- RAM[130] = 0xA5 -> page 1, cs1, data byte 3 is 0xA5 (0x5A with LCD_INVERT_EN defined).
- refresh_en dropped at page 3 -> the frame completes through page 7, then busy = 0 with no further E pulses. Reasserting it restarts at 0xB8 on page 0.
- rst asserted while lcd_e = 1 -> lcd_e, lcd_rst_n and busy drop to 0 in the same cycle. After release the full power-up and init sequence repeats.
